ps2_keyboard: RTL

- PS/2 keyboard receiver: deserialises device-to-host frames, folds E0/F0 prefixes into flags and buffers key events in a small FIFO.
- Sits directly upstream of the scancode-to-ASCII lookup. The CPU pops an event here, then uses key_code[7:0] as the ROM index; addr[9:2] = code.
- Polled by the CPU through the memory-mapped I/O decoder.

---
 rtl/ps2_keyboard.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/ps2_keyboard.sv
// ============================================================================
// Module   : ps2_keyboard
// Brief    : PS/2 keyboard receiver with E0/F0 prefix folding and event FIFO.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ps2_keyboard #(
  parameter int FIFO_AW        = 3,
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 20000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ps2_clk,
  input  logic               ps2_data,
  input  logic               rd_en,
  input  logic               clr_err,
  output logic               rd_valid,
  output logic [7:0]         key_code,
  output logic               key_break,
  output logic               key_ext,
  output logic [FIFO_AW:0]   fifo_count,
  output logic               overflow,
  output logic               parity_err
);

  localparam int c_depth = 1 << FIFO_AW;
  localparam int c_fcw   = $clog2(FILTER_LEN + 1);
  localparam int c_tcw   = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic             r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;
  logic             r_filt, r_fall;
  logic [c_fcw-1:0] r_filt_cnt;

  state_t           r_state;
  logic [2:0]       r_bit_cnt;
  logic [7:0]       r_shift;
  logic             r_par;
  logic [c_tcw-1:0] r_tmo;
  logic             r_done, r_ok;

  logic             r_ext, r_brk;
  logic [9:0]       r_mem [c_depth];
  logic [FIFO_AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [FIFO_AW:0] r_count;
  logic             r_overflow, r_parity_err;

  logic w_is_e0, w_is_f0, w_push, w_pop, w_full, w_wr;

  // Synchronise both pins; the clock line must hold a new level for
  // FILTER_LEN samples before the filtered copy follows it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_clk_s1   <= 1'b1;
      r_clk_s2   <= 1'b1;
      r_dat_s1   <= 1'b1;
      r_dat_s2   <= 1'b1;
      r_filt     <= 1'b1;
      r_filt_cnt <= '0;
      r_fall     <= 1'b0;
    end else begin
      r_clk_s1 <= ps2_clk;
      r_clk_s2 <= r_clk_s1;
      r_dat_s1 <= ps2_data;
      r_dat_s2 <= r_dat_s1;
      r_fall   <= 1'b0;
      if (r_clk_s2 == r_filt) begin
        r_filt_cnt <= '0;
      end else if (r_filt_cnt == c_fcw'(FILTER_LEN - 1)) begin
        r_filt     <= r_clk_s2;
        r_filt_cnt <= '0;
        r_fall     <= r_filt;
      end else begin
        r_filt_cnt <= r_filt_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_par     <= 1'b0;
      r_tmo     <= '0;
      r_done    <= 1'b0;
      r_ok      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_fall) begin
        r_tmo <= '0;
        case (r_state)
          IDLE: begin
            if (!r_dat_s2) begin
              r_state   <= DATA;
              r_bit_cnt <= '0;
            end
          end
          DATA: begin
            r_shift   <= {r_dat_s2, r_shift[7:1]};
            r_bit_cnt <= r_bit_cnt + 1'b1;
            if (r_bit_cnt == 3'd7) r_state <= PARITY;
          end
          PARITY: begin
            r_par   <= r_dat_s2;
            r_state <= STOP;
          end
          default: begin
            r_done  <= 1'b1;
            r_ok    <= (^{r_shift, r_par}) & r_dat_s2;
            r_state <= IDLE;
          end
        endcase
      end else if (r_state != IDLE) begin
        if (r_tmo == c_tcw'(TIMEOUT_CYCLES - 1)) begin
          r_state <= IDLE;
          r_tmo   <= '0;
        end else begin
          r_tmo <= r_tmo + 1'b1;
        end
      end else begin
        r_tmo <= '0;
      end
    end
  end

  always_comb begin
    w_is_e0 = (r_shift == 8'hE0);
    w_is_f0 = (r_shift == 8'hF0);
    w_push  = r_done & r_ok & ~w_is_e0 & ~w_is_f0;
    w_pop   = rd_en & (r_count != '0);
    w_full  = (r_count == (FIFO_AW + 1)'(c_depth));
    // A pop in the same cycle frees the slot the push needs.
    w_wr    = w_push & (~w_full | w_pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ext        <= 1'b0;
      r_brk        <= 1'b0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_overflow   <= 1'b0;
      r_parity_err <= 1'b0;
      for (int i = 0; i < c_depth; i++) r_mem[i] <= '0;
    end else begin
      if (r_done) begin
        if (!r_ok) begin
          r_ext <= 1'b0;
          r_brk <= 1'b0;
        end else if (w_is_e0) begin
          r_ext <= 1'b1;
        end else if (w_is_f0) begin
          r_brk <= 1'b1;
        end else begin
          r_ext <= 1'b0;
          r_brk <= 1'b0;
        end
      end
      if (w_wr) begin
        r_mem[r_wr_ptr] <= {r_ext, r_brk, r_shift};
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_push & w_full & ~w_pop) r_overflow <= 1'b1;
      else if (clr_err)             r_overflow <= 1'b0;
      if (r_done & ~r_ok)           r_parity_err <= 1'b1;
      else if (clr_err)             r_parity_err <= 1'b0;
    end
  end

  assign rd_valid   = (r_count != '0);
  assign key_code   = r_mem[r_rd_ptr][7:0];
  assign key_break  = r_mem[r_rd_ptr][8];
  assign key_ext    = r_mem[r_rd_ptr][9];
  assign fifo_count = r_count;
  assign overflow   = r_overflow;
  assign parity_err = r_parity_err;

endmodule

`default_nettype wire
